// File: rtl/mul_sched_if.sv
// Bundle of request, response and datapath-control signals for the
// Booth/Wallace multiplier scheduler. The scheduler uses the slave view;
// the surrounding system (requesters, consumer, datapath) uses the master view.
interface mul_sched_if #(
  parameter int LAT   = 3,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic             req0_signed;
  logic             req1_signed;
  logic [31:0]      req0_x;
  logic [31:0]      req0_y;
  logic [31:0]      req1_x;
  logic [31:0]      req1_y;
  logic [TAG_W-1:0] req0_tag;
  logic [TAG_W-1:0] req1_tag;
  logic             flush;
  logic [32:0]      dp_x;
  logic [32:0]      dp_y;
  logic [LAT-1:0]   dp_en;
  logic [63:0]      dp_prod;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic [63:0]      rsp_prod;

  modport slave (
    input  req0_valid, req1_valid, req0_signed, req1_signed,
    input  req0_x, req0_y, req1_x, req1_y, req0_tag, req1_tag,
    input  flush, dp_prod, rsp_ready,
    output req0_ready, req1_ready, dp_x, dp_y, dp_en,
    output rsp_valid, rsp_src, rsp_tag, rsp_prod
  );

  modport master (
    output req0_valid, req1_valid, req0_signed, req1_signed,
    output req0_x, req0_y, req1_x, req1_y, req0_tag, req1_tag,
    output flush, dp_prod, rsp_ready,
    input  req0_ready, req1_ready, dp_x, dp_y, dp_en,
    input  rsp_valid, rsp_src, rsp_tag, rsp_prod
  );
endinterface

// File: rtl/mul_sched.sv
// Scheduler / pipeline controller for the radix-4 Booth multiplier datapath.
// Round-robin arbitration between two requesters, operand sign extension to
// 33 bits, per-stage load enables with bubble compression, and tag/source
// tracking for every operation in flight. Operands live only in the datapath.
module mul_sched #(
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      resetn,
  mul_sched_if.slave bus
);

  logic [LAT-1:0]   r_v;
  logic [LAT-1:0]   r_src;
  logic [TAG_W-1:0] r_tag [LAT];
  logic             r_rr;

  logic [LAT-1:0]   w_mv;
  logic             w_go;
  logic             w_slot;
  logic             w_any;
  logic             w_both;
  logic             w_gidx;
  logic             w_accept;
  logic             w_gsigned;
  logic [31:0]      w_gx;
  logic [31:0]      w_gy;
  logic [TAG_W-1:0] w_gtag;

  // Advance chain from the output stage backwards; a stage moves when its
  // successor is empty or moving. Flush freezes every stage.
  always_comb begin
    w_mv = '0;
    w_go = bus.rsp_ready & ~bus.flush;
    for (int i = LAT - 1; i >= 0; i--) begin
      w_mv[i] = r_v[i] & w_go & ~bus.flush;
      w_go    = ~r_v[i] | w_mv[i];
    end
    w_slot = w_go;
  end

  // Round-robin grant selection and operand mux from the granted requester.
  always_comb begin
    w_any     = bus.req0_valid | bus.req1_valid;
    w_both    = bus.req0_valid & bus.req1_valid;
    w_gidx    = w_both ? r_rr : bus.req1_valid;
    w_gsigned = w_gidx ? bus.req1_signed : bus.req0_signed;
    w_gx      = w_gidx ? bus.req1_x      : bus.req0_x;
    w_gy      = w_gidx ? bus.req1_y      : bus.req0_y;
    w_gtag    = w_gidx ? bus.req1_tag    : bus.req0_tag;
    w_accept  = w_any & w_slot & ~bus.flush & resetn;
  end

  // Ready depends only on the grant and stage-0 availability, never on the
  // requester's own valid beyond selecting the grant.
  assign bus.req0_ready = w_accept & ~w_gidx;
  assign bus.req1_ready = w_accept &  w_gidx;

  // Extension to the 33-bit Booth operand form; zero when nobody requests.
  assign bus.dp_x = w_any ? {w_gsigned & w_gx[31], w_gx} : '0;
  assign bus.dp_y = w_any ? {w_gsigned & w_gy[31], w_gy} : '0;

  assign bus.dp_en     = {w_mv[LAT-2:0], w_accept};
  assign bus.rsp_valid = r_v[LAT-1] & ~bus.flush;
  assign bus.rsp_src   = r_src[LAT-1];
  assign bus.rsp_tag   = r_tag[LAT-1];
  assign bus.rsp_prod  = bus.dp_prod;

  // Stage occupancy, per-stage source/tag and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v   <= '0;
      r_src <= '0;
      r_rr  <= 1'b0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      if (w_accept && w_both) r_rr <= ~w_gidx;

      if (bus.flush) begin
        r_v <= '0;
      end else begin
        if (w_accept)     r_v[0] <= 1'b1;
        else if (w_mv[0]) r_v[0] <= 1'b0;
        for (int i = 1; i < LAT; i++) begin
          if (w_mv[i-1])    r_v[i] <= 1'b1;
          else if (w_mv[i]) r_v[i] <= 1'b0;
        end
      end

      if (w_accept) begin
        r_src[0] <= w_gidx;
        r_tag[0] <= w_gtag;
      end
      for (int i = 1; i < LAT; i++) begin
        if (w_mv[i-1]) begin
          r_src[i] <= r_src[i-1];
          r_tag[i] <= r_tag[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural multiplier datapath that
// obeys dp_en and multiplies the 33-bit extended operands.
module tb_mul_sched;
  localparam int LAT   = 3;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  mul_sched_if #(.LAT(LAT), .TAG_W(TAG_W)) bus ();
  mul_sched #(.LAT(LAT), .TAG_W(TAG_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural datapath: operands shift through LAT stages under dp_en.
  logic [32:0] sx [LAT];
  logic [32:0] sy [LAT];
  logic signed [65:0] ax, ay, prod_full;
  always_ff @(posedge clk) begin
    if (bus.dp_en[0]) begin sx[0] <= bus.dp_x; sy[0] <= bus.dp_y; end
    for (int i = 1; i < LAT; i++)
      if (bus.dp_en[i]) begin sx[i] <= sx[i-1]; sy[i] <= sy[i-1]; end
  end
  assign ax = 66'($signed(sx[LAT-1]));
  assign ay = 66'($signed(sy[LAT-1]));
  assign prod_full = ax * ay;
  assign bus.dp_prod = prod_full[63:0];

  // Expected-response queue
  logic             eq_src  [32];
  logic [TAG_W-1:0] eq_tag  [32];
  logic [63:0]      eq_prod [32];
  int wr, rd;
  int k0, k1;
  logic exp_g;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic s, input logic [TAG_W-1:0] t, input logic [63:0] p);
    eq_src[wr] = s; eq_tag[wr] = t; eq_prod[wr] = p; wr++;
  endtask

  task automatic next_operands(input logic s);
    if (!s) begin
      k0++; bus.req0_x = 32'h1000 + 32'(k0); bus.req0_tag = TAG_W'(k0);
    end else begin
      k1++; bus.req1_x = 32'd5 + 32'(k1); bus.req1_tag = TAG_W'(8 + k1);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick; tick; #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    checks++; if (bus.dp_en !== '0) begin errors++; $display("FAIL reset_dp_en got %b want 0", bus.dp_en); end
    checks++; if (bus.dp_x !== 33'h0) begin errors++; $display("FAIL reset_dp_x got %h want 0", bus.dp_x); end
    tick;
    resetn = 1'b1;
  endtask

  task automatic test_single;
    int n;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_signed = 1'b0;
    bus.req0_x = 32'hFFFFFFFF; bus.req0_y = 32'hFFFFFFFF; bus.req0_tag = 4'd5;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    checks++; if (bus.dp_x !== 33'h0FFFFFFFF) begin errors++; $display("FAIL single_dp_x got %h want 0ffffffff", bus.dp_x); end
    checks++; if (bus.dp_en !== LAT'(1)) begin errors++; $display("FAIL single_dp_en got %b want 001", bus.dp_en); end
    tick;
    bus.req0_valid = 1'b0;
    n = 1; #1;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick; #1; n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", n, LAT); end
    checks++; if (bus.rsp_prod !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL single_prod got %h want fffffffe00000001", bus.rsp_prod); end
    checks++; if (bus.rsp_src !== 1'b0 || bus.rsp_tag !== 4'd5) begin errors++; $display("FAIL single_src_tag got %b/%0d want 0/5", bus.rsp_src, bus.rsp_tag); end
    tick; #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_signed;
    logic        t_src  [2] = '{1'b1, 1'b0};
    logic [31:0] t_x    [2] = '{32'hFFFFFFFF, 32'h80000000};
    logic [31:0] t_y    [2] = '{32'h00000002, 32'h80000000};
    logic [3:0]  t_tag  [2] = '{4'd9, 4'd2};
    logic [63:0] t_exp  [2] = '{64'hFFFFFFFFFFFFFFFE, 64'h4000000000000000};
    int n;
    for (int k = 0; k < 2; k++) begin
      bus.req0_x = 32'h12345678; bus.req0_y = 32'h9ABCDEF0; bus.req0_signed = 1'b0;
      bus.req1_x = 32'h0F0F0F0F; bus.req1_y = 32'hF0F0F0F0; bus.req1_signed = 1'b0;
      if (t_src[k]) begin
        bus.req1_valid = 1'b1; bus.req1_signed = 1'b1; bus.req1_x = t_x[k]; bus.req1_y = t_y[k]; bus.req1_tag = t_tag[k];
      end else begin
        bus.req0_valid = 1'b1; bus.req0_signed = 1'b1; bus.req0_x = t_x[k]; bus.req0_y = t_y[k]; bus.req0_tag = t_tag[k];
      end
      #1;
      if (k == 0) begin
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL signed_ready got %b%b want 01", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.dp_x !== 33'h1FFFFFFFF || bus.dp_y !== 33'h000000002) begin errors++; $display("FAIL signed_ext got %h/%h want 1ffffffff/000000002", bus.dp_x, bus.dp_y); end
      end
      tick;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      n = 1; #1;
      while (bus.rsp_valid !== 1'b1 && n < 10) begin tick; #1; n++; end
      checks++; if (n !== LAT) begin errors++; $display("FAIL signed_latency%0d got %0d want %0d", k, n, LAT); end
      checks++; if (bus.rsp_prod !== t_exp[k]) begin errors++; $display("FAIL signed_prod%0d got %h want %h", k, bus.rsp_prod, t_exp[k]); end
      checks++; if (bus.rsp_src !== t_src[k] || bus.rsp_tag !== t_tag[k]) begin errors++; $display("FAIL signed_src_tag%0d got %b/%0d want %b/%0d", k, bus.rsp_src, bus.rsp_tag, t_src[k], t_tag[k]); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int acc, cyc;
    logic got, gs;
    wr = 0; rd = 0; k0 = 0; k1 = 0; exp_g = 1'b0; acc = 0; cyc = 0;
    bus.rsp_ready = 1'b1;
    bus.req0_signed = 1'b0; bus.req1_signed = 1'b0;
    bus.req0_x = 32'h1000; bus.req0_y = 32'd3;          bus.req0_tag = 4'd0;
    bus.req1_x = 32'd5;    bus.req1_y = 32'hFFFFFFFF;   bus.req1_tag = 4'd8;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    while ((acc < 8 || rd < 8) && cyc < 40) begin
      #1;
      got = 1'b0; gs = 1'b0;
      if (bus.req0_valid && bus.req0_ready) begin
        got = 1'b1; gs = 1'b0;
        push(1'b0, bus.req0_tag, {32'h0, bus.req0_x} * {32'h0, bus.req0_y});
      end else if (bus.req1_valid && bus.req1_ready) begin
        got = 1'b1; gs = 1'b1;
        push(1'b1, bus.req1_tag, {32'h0, bus.req1_x} * {32'h0, bus.req1_y});
      end
      if (acc < 8) begin
        checks++; if (got !== 1'b1 || gs !== exp_g) begin errors++; $display("FAIL b2b_grant%0d got %b/%b want 1/%b", acc, got, gs, exp_g); end
      end
      if (bus.rsp_valid) begin
        checks++;
        if (rd >= wr || bus.rsp_src !== eq_src[rd] || bus.rsp_tag !== eq_tag[rd] || bus.rsp_prod !== eq_prod[rd]) begin
          errors++; $display("FAIL b2b_rsp%0d got %b/%0d/%h want %b/%0d/%h", rd, bus.rsp_src, bus.rsp_tag, bus.rsp_prod, eq_src[rd], eq_tag[rd], eq_prod[rd]);
        end
        rd++;
      end
      tick;
      if (got) begin acc++; exp_g = ~exp_g; next_operands(gs); end
      if (acc >= 8) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
      cyc++;
    end
    checks++; if (cyc !== 8 + LAT) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc, 8 + LAT); end
  endtask

  task automatic test_stall;
    int acc;
    logic got, gs;
    wr = 0; rd = 0; acc = 0; exp_g = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      got = 1'b0; gs = 1'b0;
      if (bus.req0_valid && bus.req0_ready) begin
        got = 1'b1; gs = 1'b0; push(1'b0, bus.req0_tag, {32'h0, bus.req0_x} * {32'h0, bus.req0_y});
      end else if (bus.req1_valid && bus.req1_ready) begin
        got = 1'b1; gs = 1'b1; push(1'b1, bus.req1_tag, {32'h0, bus.req1_x} * {32'h0, bus.req1_y});
      end
      tick;
      if (got) begin acc++; exp_g = ~exp_g; next_operands(gs); end
    end
    #1;
    checks++; if (acc !== LAT) begin errors++; $display("FAIL stall_accepts got %0d want %0d", acc, LAT); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00 || bus.dp_en !== '0) begin errors++; $display("FAIL stall_full got %b%b/%b want 00/000", bus.req0_ready, bus.req1_ready, bus.dp_en); end
    bus.rsp_ready = 1'b1;
    #1;
    got = exp_g ? bus.req1_ready : bus.req0_ready;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL stall_release_accept got %b want 1", got); end
    if (exp_g) push(1'b1, bus.req1_tag, {32'h0, bus.req1_x} * {32'h0, bus.req1_y});
    else       push(1'b0, bus.req0_tag, {32'h0, bus.req0_x} * {32'h0, bus.req0_y});
    for (int c = 0; c < 12; c++) begin
      if (c > 0) #1;
      if (bus.rsp_valid) begin
        checks++;
        if (rd >= wr || bus.rsp_src !== eq_src[rd] || bus.rsp_tag !== eq_tag[rd] || bus.rsp_prod !== eq_prod[rd]) begin
          errors++; $display("FAIL stall_rsp%0d got %b/%0d/%h want %b/%0d/%h", rd, bus.rsp_src, bus.rsp_tag, bus.rsp_prod, eq_src[rd], eq_tag[rd], eq_prod[rd]);
        end
        rd++;
      end
      tick;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    end
    checks++; if (rd !== LAT + 1 || wr !== LAT + 1) begin errors++; $display("FAIL stall_drain got %0d of %0d want %0d", rd, wr, LAT + 1); end
  endtask

  task automatic test_flush;
    int n;
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_signed = 1'b0; bus.req0_x = 32'd10; bus.req0_y = 32'd20; bus.req0_tag = 4'd1;
    for (int c = 0; c < LAT; c++) tick;
    #1;
    checks++; if (bus.req0_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_fill got %b/%b want 0/1", bus.req0_ready, bus.rsp_valid); end
    bus.flush = 1'b1; bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.dp_en !== '0) begin errors++; $display("FAIL flush_cycle got %b/%b/%b want 0/0/000", bus.rsp_valid, bus.req0_ready, bus.dp_en); end
    tick;
    bus.flush = 1'b0; bus.req0_x = 32'd7; bus.req0_y = 32'd6; bus.req0_tag = 4'd3;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b want 1", bus.req0_ready); end
    tick;
    bus.req0_valid = 1'b0;
    n = 1; #1;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick; #1; n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL flush_latency got %0d want %0d", n, LAT); end
    checks++; if (bus.rsp_prod !== 64'd42 || bus.rsp_tag !== 4'd3) begin errors++; $display("FAIL flush_new_op got %h/%0d want 2a/3", bus.rsp_prod, bus.rsp_tag); end
    tick; #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.rsp_ready = 1'b1;
    bus.req0_x = 32'd3; bus.req0_y = 32'd4; bus.req0_tag = 4'd1;
    bus.req1_x = 32'd5; bus.req1_y = 32'd6; bus.req1_tag = 4'd2;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    tick;
    bus.req0_valid = 1'b0;
    tick;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    resetn = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || {bus.req0_ready, bus.req1_ready} !== 2'b00 || bus.dp_en !== '0) begin errors++; $display("FAIL midreset_outputs got %b/%b%b/%b want 0/00/000", bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.dp_en); end
    tick;
    resetn = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL midreset_rr got %b%b want 10", bus.req0_ready, bus.req1_ready); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 2 * LAT + 2; c++) begin
      #1;
      if (bus.rsp_valid === 1'b1) seen++;
      tick;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_stale got %0d want 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_signed = 1'b0; bus.req1_signed = 1'b0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req1_x = '0; bus.req1_y = '0;
    bus.req0_tag = '0; bus.req1_tag = '0;
    bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    test_reset;
    test_single;
    test_signed;
    test_back_to_back;
    test_stall;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
